// File: rtl/dmem_bus_ctrl.sv
// dmem_bus_ctrl
//   Data-memory bus controller for the MEM stage of a pipelined core.
//   It turns a single load or store request into one handshaked bus
//   transaction, stalls the pipeline while that transaction is pending, and
//   returns aligned, extended load data. Misaligned accesses and bus
//   timeouts finish without completing a transfer and raise a one-cycle
//   fault pulse.
//
//   Ports
//     clk        in   clock, all state changes on the rising edge
//     reset      in   synchronous, active-high
//     MemRead    in   load request from the MEM stage
//     MemWrite   in   store request from the MEM stage
//     addr       in   byte address
//     wr_data    in   store data, lane 0 aligned
//     func3      in   access size/sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
//     stall      out  freezes the pipeline while the access is pending
//     rd_data    out  aligned, extended load result (held between loads)
//     bus_valid  out  bus request valid
//     bus_we     out  1 = write, 0 = read
//     bus_addr   out  word-aligned bus address
//     bus_be     out  byte-lane enables
//     bus_wdata  out  lane-replicated store data
//     bus_ready  in   slave accepts/completes the request this cycle
//     bus_rdata  in   read data
//     fault      out  one-cycle pulse after a misaligned access or timeout
module dmem_bus_ctrl #(
   parameter int DATA_W     = 32,
   parameter int DM_ADDRESS = 9,
   parameter int TO_W       = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic [2:0]            func3,
   output logic                  stall,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  bus_valid,
   output logic                  bus_we,
   output logic [DM_ADDRESS-1:0] bus_addr,
   output logic [3:0]            bus_be,
   output logic [DATA_W-1:0]     bus_wdata,
   input  logic                  bus_ready,
   input  logic [DATA_W-1:0]     bus_rdata,
   output logic                  fault
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

   // Last value the wait counter takes before the timeout fires; the
   // increment on that cycle leaves the counter at all-ones, so the request
   // is presented for (2**TO_W - 1) cycles in total.
   localparam logic [TO_W-1:0] TO_LAST = {{(TO_W-1){1'b1}}, 1'b0};

   state_t                  state_q, state_d;
   logic                    we_q, we_d;
   logic [DM_ADDRESS-1:0]   baddr_q, baddr_d;
   logic [3:0]              be_q, be_d;
   logic [DATA_W-1:0]       wdata_q, wdata_d;
   logic [DATA_W-1:0]       rd_q, rd_d;
   logic                    fault_q, fault_d;
   logic [TO_W-1:0]         to_q, to_d;
   logic [2:0]              f3_q, f3_d;
   logic [1:0]              lane_q, lane_d;

   logic                    one_req;
   size_t                   req_size;
   logic                    misaligned;

   // Loads know the unsigned variants; for stores anything other than
   // B/H is a word access.
   function automatic size_t size_of(input logic is_load, input logic [2:0] f);
      size_t s;
      s = SZ_W;
      if (is_load) begin
         case (f)
            3'b000, 3'b100: s = SZ_B;
            3'b001, 3'b101: s = SZ_H;
            default:        s = SZ_W;
         endcase
      end else begin
         case (f)
            3'b000:  s = SZ_B;
            3'b001:  s = SZ_H;
            default: s = SZ_W;
         endcase
      end
      return s;
   endfunction

   function automatic logic [3:0] lane_mask(input size_t s, input logic [1:0] a);
      logic [3:0] m;
      case (s)
         SZ_B:    m = 4'b0001 << a;
         SZ_H:    m = 4'b0011 << a;
         default: m = 4'b1111;
      endcase
      return m;
   endfunction

   function automatic logic [DATA_W-1:0] replicate(input size_t s,
                                                   input logic [DATA_W-1:0] w);
      logic [DATA_W-1:0] r;
      case (s)
         SZ_B:    r = {(DATA_W/8){w[7:0]}};
         SZ_H:    r = {(DATA_W/16){w[15:0]}};
         default: r = w;
      endcase
      return r;
   endfunction

   // Shift the addressed lane down to bit 0, then extend per func3.
   function automatic logic [DATA_W-1:0] extract(input logic [DATA_W-1:0] d,
                                                 input logic [1:0] a,
                                                 input logic [2:0] f);
      logic [DATA_W-1:0] sh;
      logic [DATA_W-1:0] r;
      sh = d >> {a, 3'b000};
      case (f)
         3'b000:  r = {{(DATA_W-8){sh[7]}}, sh[7:0]};
         3'b100:  r = {{(DATA_W-8){1'b0}}, sh[7:0]};
         3'b001:  r = {{(DATA_W-16){sh[15]}}, sh[15:0]};
         3'b101:  r = {{(DATA_W-16){1'b0}}, sh[15:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   assign one_req    = MemRead ^ MemWrite;
   assign req_size   = size_of(MemRead, func3);
   assign misaligned = ((req_size == SZ_H) && addr[0]) ||
                       ((req_size == SZ_W) && (addr[1:0] != 2'b00));

   always_comb begin
      state_d = state_q;
      we_d    = we_q;
      baddr_d = baddr_q;
      be_d    = be_q;
      wdata_d = wdata_q;
      rd_d    = rd_q;
      fault_d = 1'b0;
      to_d    = to_q;
      f3_d    = f3_q;
      lane_d  = lane_q;
      case (state_q)
         IDLE: begin
            // Both request lines set is a NOP and falls through here.
            if (one_req) begin
               if (misaligned) begin
                  state_d = DONE;
                  fault_d = 1'b1;
                  if (MemRead) rd_d = '0;
               end else begin
                  state_d = REQ;
                  we_d    = MemWrite;
                  baddr_d = {addr[DM_ADDRESS-1:2], 2'b00};
                  be_d    = lane_mask(req_size, addr[1:0]);
                  wdata_d = replicate(req_size, wr_data);
                  f3_d    = func3;
                  lane_d  = addr[1:0];
                  to_d    = '0;
               end
            end
         end
         REQ: begin
            if (bus_ready) begin
               state_d = DONE;
               if (!we_q) rd_d = extract(bus_rdata, lane_q, f3_q);
            end else begin
               to_d = to_q + 1'b1;
               if (to_q == TO_LAST) begin
                  state_d = DONE;
                  fault_d = 1'b1;
                  if (!we_q) rd_d = '0;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         we_q    <= 1'b0;
         baddr_q <= '0;
         be_q    <= '0;
         wdata_q <= '0;
         rd_q    <= '0;
         fault_q <= 1'b0;
         to_q    <= '0;
         f3_q    <= '0;
         lane_q  <= '0;
      end else begin
         state_q <= state_d;
         we_q    <= we_d;
         baddr_q <= baddr_d;
         be_q    <= be_d;
         wdata_q <= wdata_d;
         rd_q    <= rd_d;
         fault_q <= fault_d;
         to_q    <= to_d;
         f3_q    <= f3_d;
         lane_q  <= lane_d;
      end
   end

   // The pipeline must be free to move while reset is held.
   assign stall     = !reset && (((state_q == IDLE) && one_req) || (state_q == REQ));
   assign bus_valid = (state_q == REQ);
   assign bus_we    = we_q;
   assign bus_addr  = baddr_q;
   assign bus_be    = be_q;
   assign bus_wdata = wdata_q;
   assign rd_data   = rd_q;
   assign fault     = fault_q;

endmodule
